// File: rtl/spi_slave_sync.sv
// Mode-0 SPI slave running entirely on the system clock: LOAD/SCLK/MOSI are
// synchronized and edge-detected, one N-bit frame is shifted each way MSB-first.
module spi_slave_sync #(
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         RESET,
    input  logic         LOAD,
    input  logic         SCLK,
    input  logic         MOSI,
    input  logic [N-1:0] STX_DAT,
    output logic         MISO,
    output logic [N-1:0] SRX_DAT,
    output logic         rx_ok,
    output logic         rx_err,
    output logic         busy,
    output logic [N-1:0] sr_STX,
    output logic [N-1:0] sr_SRX,
    output logic [3:0]   cb_bit
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_N = 4'(N);

    state_t     state;
    logic [2:0] ld_q;
    logic [2:0] sck_q;
    logic [1:0] mosi_q;

    logic ld_fall, ld_rise, sck_rise, sck_fall, mosi_s;

    // Stages [0],[1] form the 2-FF synchronizer; [2] is the edge-detect register.
    // NOTE: the LOAD synchronizer resets to 0 (not its idle 1) so a reset taken
    // mid-frame can never fabricate a LOAD falling edge and restart the frame.
    always_ff @(posedge clk) begin
        if (RESET) begin
            ld_q   <= '0;
            sck_q  <= '0;
            mosi_q <= '0;
        end else begin
            ld_q   <= {ld_q[1:0], LOAD};
            sck_q  <= {sck_q[1:0], SCLK};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign ld_fall  = ~ld_q[1] &  ld_q[2];
    assign ld_rise  =  ld_q[1] & ~ld_q[2];
    assign sck_rise =  sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] &  sck_q[2];
    assign mosi_s   =  mosi_q[1];

    assign busy = (state == SHIFT);

    // NOTE: every state register below uses non-blocking assignment so all
    // branches see the pre-edge values of state, counters and shift registers.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= WAIT;
            MISO    <= 1'b0;
            SRX_DAT <= '0;
            rx_ok   <= 1'b0;
            rx_err  <= 1'b0;
            sr_STX  <= '0;
            sr_SRX  <= '0;
            cb_bit  <= '0;
        end else begin
            rx_ok  <= 1'b0;
            rx_err <= 1'b0;
            MISO   <= (state == SHIFT) ? sr_STX[N-1] : 1'b0;

            case (state)
                WAIT: begin
                    if (ld_q[1])
                        state <= IDLE;
                end
                IDLE: begin
                    if (ld_fall) begin
                        sr_STX <= STX_DAT;
                        sr_SRX <= '0;
                        cb_bit <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A bit arriving together with LOAD rising is still counted.
                    if (sck_rise) begin
                        sr_SRX <= {sr_SRX[N-2:0], mosi_s};
                        if (cb_bit != 4'hF)
                            cb_bit <= cb_bit + 4'd1;
                    end
                    if (sck_fall)
                        sr_STX <= {sr_STX[N-2:0], 1'b0};
                    if (ld_rise)
                        state <= DONE;
                end
                DONE: begin
                    if (cb_bit == CNT_N) begin
                        SRX_DAT <= sr_SRX;
                        rx_ok   <= 1'b1;
                    end else begin
                        rx_err  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a behavioural SPI master drives frames,
// and each scenario task compares against hand-computed values.
module tb_spi_slave_sync;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         RESET;
    logic         LOAD;
    logic         SCLK;
    logic         MOSI;
    logic [N-1:0] STX_DAT;
    logic         MISO;
    logic [N-1:0] SRX_DAT;
    logic         rx_ok;
    logic         rx_err;
    logic         busy;
    logic [N-1:0] sr_STX;
    logic [N-1:0] sr_SRX;
    logic [3:0]   cb_bit;

    int total = 0;
    int bad   = 0;
    int ok_cnt  = 0;
    int err_cnt = 0;
    logic [N-1:0] rx_log[$];

    // Snapshot taken right after a mid-frame reset pulse.
    logic         snap_miso, snap_ok, snap_err, snap_busy;
    logic [N-1:0] snap_srx, snap_stx, snap_srsrx;
    logic [3:0]   snap_cb;

    spi_slave_sync #(.N(N)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .LOAD    (LOAD),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .STX_DAT (STX_DAT),
        .MISO    (MISO),
        .SRX_DAT (SRX_DAT),
        .rx_ok   (rx_ok),
        .rx_err  (rx_err),
        .busy    (busy),
        .sr_STX  (sr_STX),
        .sr_SRX  (sr_SRX),
        .cb_bit  (cb_bit)
    );

    always #5 clk = ~clk;

    // Strobe monitor on the falling edge.
    always @(negedge clk) begin
        if (rx_ok) begin
            ok_cnt++;
            rx_log.push_back(SRX_DAT);
        end
        if (rx_err)
            err_cnt++;
        if (rx_ok && rx_err) begin
            total++;
            bad++;
            $display("FAIL strobe_exclusive: rx_ok=%b rx_err=%b required not both", rx_ok, rx_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One master frame. rst_pulse / chg_pulse = -1 disables those events.
    task automatic run_frame(input logic [N-1:0] w, input int pulses, input int hi, input int lo,
                             input int rst_pulse, input int chg_pulse, input logic [N-1:0] chg_val,
                             output logic [N-1:0] miso_w);
        logic [N-1:0] sh;
        sh     = w;
        miso_w = '0;
        LOAD   = 1'b0;
        MOSI   = sh[N-1];
        tick((lo < 5) ? 5 : lo);
        for (int i = 0; i < pulses; i++) begin
            SCLK = 1'b1;
            if (i < N)
                miso_w = {miso_w[N-2:0], MISO};
            if (i == chg_pulse)
                STX_DAT = chg_val;
            tick(hi);
            if (i == rst_pulse) begin
                RESET = 1'b1;
                tick(1);
                snap_miso  = MISO;
                snap_ok    = rx_ok;
                snap_err   = rx_err;
                snap_busy  = busy;
                snap_srx   = SRX_DAT;
                snap_stx   = sr_STX;
                snap_srsrx = sr_SRX;
                snap_cb    = cb_bit;
                RESET = 1'b0;
            end
            SCLK = 1'b0;
            sh   = {sh[N-2:0], 1'b0};
            MOSI = sh[N-1];
            tick(lo);
        end
        LOAD = 1'b1;
    endtask

    task automatic test_reset;
        RESET   = 1'b1;
        LOAD    = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        STX_DAT = '0;
        tick(3);
        total++;
        if ({MISO, rx_ok, rx_err, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got MISO/ok/err/busy=%b required 0000", {MISO, rx_ok, rx_err, busy});
        end
        total++;
        if ({SRX_DAT, sr_STX, sr_SRX, cb_bit} !== '0) begin
            bad++;
            $display("FAIL reset_regs: got SRX=%h stx=%h srx=%h cb=%0d required all 0", SRX_DAT, sr_STX, sr_SRX, cb_bit);
        end
        RESET = 1'b0;
        tick(6);
    endtask

    task automatic test_nominal;
        logic [N-1:0] mw;
        STX_DAT = 9'b111011011;
        run_frame(9'b101111010, 9, 10, 10, -1, -1, '0, mw);
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            total++;
            if (rx_ok !== (c == 4)) begin
                bad++;
                $display("FAIL nominal_rx_ok_c%0d: got %b required %b", c, rx_ok, (c == 4));
            end
            if (c == 4) begin
                total++;
                if (SRX_DAT !== 9'b101111010) begin
                    bad++;
                    $display("FAIL nominal_srx: got %b required 101111010", SRX_DAT);
                end
            end
        end
        total++;
        if (mw !== 9'b111011011) begin
            bad++;
            $display("FAIL nominal_miso: got %b required 111011011", mw);
        end
        total++;
        if (cb_bit !== 4'd9) begin
            bad++;
            $display("FAIL nominal_cb_bit: got %0d required 9", cb_bit);
        end
        total++;
        if (ok_cnt !== 1 || err_cnt !== 0) begin
            bad++;
            $display("FAIL nominal_counts: got ok=%0d err=%0d required 1/0", ok_cnt, err_cnt);
        end
        tick(4);
    endtask

    task automatic test_bad_length;
        logic [N-1:0] mw;
        run_frame(9'h155, 8, 10, 10, -1, -1, '0, mw);
        tick(8);
        total++;
        if (ok_cnt !== 1 || err_cnt !== 1 || SRX_DAT !== 9'b101111010 || cb_bit !== 4'd8) begin
            bad++;
            $display("FAIL short_frame: got ok=%0d err=%0d srx=%b cb=%0d required 1/1/101111010/8", ok_cnt, err_cnt, SRX_DAT, cb_bit);
        end
        run_frame(9'h0F0, 10, 10, 10, -1, -1, '0, mw);
        tick(8);
        total++;
        if (ok_cnt !== 1 || err_cnt !== 2 || SRX_DAT !== 9'b101111010 || cb_bit !== 4'd10) begin
            bad++;
            $display("FAIL long_frame: got ok=%0d err=%0d srx=%b cb=%0d required 1/2/101111010/10", ok_cnt, err_cnt, SRX_DAT, cb_bit);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] mw;
        run_frame(9'h1FF, 9, 3, 3, -1, -1, '0, mw);
        tick(4);
        run_frame(9'h000, 9, 3, 3, -1, -1, '0, mw);
        tick(8);
        total++;
        if (ok_cnt !== 3 || err_cnt !== 2) begin
            bad++;
            $display("FAIL b2b_counts: got ok=%0d err=%0d required 3/2", ok_cnt, err_cnt);
        end
        total++;
        if (rx_log.size() < 2) begin
            bad++;
            $display("FAIL b2b_log: got %0d entries required at least 2", rx_log.size());
        end else if (rx_log[rx_log.size()-2] !== 9'h1FF || rx_log[rx_log.size()-1] !== 9'h000) begin
            bad++;
            $display("FAIL b2b_words: got %h,%h required 1ff,000", rx_log[rx_log.size()-2], rx_log[rx_log.size()-1]);
        end
    endtask

    task automatic test_stx_change;
        logic [N-1:0] mw;
        STX_DAT = 9'b111011011;
        run_frame(9'h0A5, 9, 10, 10, -1, 3, 9'h000, mw);
        tick(8);
        total++;
        if (mw !== 9'b111011011) begin
            bad++;
            $display("FAIL stx_hold_miso: got %b required 111011011", mw);
        end
        run_frame(9'h15A, 9, 10, 10, -1, -1, '0, mw);
        tick(8);
        total++;
        if (mw !== 9'h000) begin
            bad++;
            $display("FAIL stx_next_miso: got %b required 000000000", mw);
        end
        total++;
        if (SRX_DAT !== 9'h15A || ok_cnt !== 5) begin
            bad++;
            $display("FAIL stx_rx: got srx=%h ok=%0d required 15a/5", SRX_DAT, ok_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] mw;
        STX_DAT = 9'h1C3;
        run_frame(9'h0F0, 9, 10, 10, 3, -1, '0, mw);
        tick(8);
        total++;
        if ({snap_miso, snap_ok, snap_err, snap_busy} !== 4'b0000 ||
            {snap_srx, snap_stx, snap_srsrx, snap_cb} !== '0) begin
            bad++;
            $display("FAIL reset_mid_values: got miso=%b ok=%b err=%b busy=%b srx=%h stx=%h srsrx=%h cb=%0d required all 0",
                     snap_miso, snap_ok, snap_err, snap_busy, snap_srx, snap_stx, snap_srsrx, snap_cb);
        end
        total++;
        if (ok_cnt !== 5 || err_cnt !== 2) begin
            bad++;
            $display("FAIL reset_mid_strobe: got ok=%0d err=%0d required 5/2", ok_cnt, err_cnt);
        end
        run_frame(9'b010101010, 9, 10, 10, -1, -1, '0, mw);
        tick(8);
        total++;
        if (SRX_DAT !== 9'b010101010 || ok_cnt !== 6 || err_cnt !== 2) begin
            bad++;
            $display("FAIL reset_recover: got srx=%b ok=%0d err=%0d required 010101010/6/2", SRX_DAT, ok_cnt, err_cnt);
        end
    endtask

    task automatic test_idle_sclk;
        MOSI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SCLK = 1'b1;
            tick(4);
            total++;
            if (MISO !== 1'b0) begin
                bad++;
                $display("FAIL idle_miso_%0d: got %b required 0", i, MISO);
            end
            SCLK = 1'b0;
            tick(4);
        end
        tick(4);
        total++;
        if (sr_SRX !== 9'b010101010 || cb_bit !== 4'd9 || ok_cnt !== 6 || err_cnt !== 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_sclk: got srx=%b cb=%0d ok=%0d err=%0d busy=%b required 010101010/9/6/2/0",
                     sr_SRX, cb_bit, ok_cnt, err_cnt, busy);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_bad_length;
        test_back_to_back;
        test_stx_change;
        test_reset_mid;
        test_idle_sclk;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
